aes_out_streamer: RTL and testbench



---
 rtl/aes_pkg.sv | 22 ++
 rtl/aes_blk_serializer.sv | 43 ++++
 rtl/aes_out_streamer.sv | 130 +++++++++++++
 tb/tb_aes_out_streamer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: output-streamer state encoding and stream geometry.
`timescale 1ns/1ps
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LATCH = 2'd2,
    ST_SEND  = 2'd3
  } aes_out_state_t;

  localparam int OUT_FIFO_DATA_WIDTH_DEF = 128;
  localparam int AXIS_DATA_WIDTH_DEF     = 32;

  // Stream words carried by one AES block.
  function automatic int words_per_blk(input int blk_w, input int word_w);
    return blk_w / word_w;
  endfunction

  localparam int WORDS_PER_BLK = words_per_blk(OUT_FIFO_DATA_WIDTH_DEF, AXIS_DATA_WIDTH_DEF);

endpackage

// File: rtl/aes_blk_serializer.sv
// Holds one AES block and presents it one stream word at a time, most
// significant word first; flags the final word of the block.
`timescale 1ns/1ps
module aes_blk_serializer
  import aes_pkg::*;
#(
  parameter int BLK_W  = OUT_FIFO_DATA_WIDTH_DEF,
  parameter int WORD_W = AXIS_DATA_WIDTH_DEF,
  parameter int WPB    = WORDS_PER_BLK
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [BLK_W-1:0]  blk,
  input  logic              advance,
  output logic [WORD_W-1:0] word,
  output logic              last_word
);

  localparam int               IDX_W    = (WPB > 1) ? $clog2(WPB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPB - 1);

  logic [BLK_W-1:0] shreg;
  logic [IDX_W-1:0] word_idx;

  // Load a fresh block, or shift the next word up to the output window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg    <= '0;
      word_idx <= '0;
    end else if (load) begin
      shreg    <= blk;
      word_idx <= '0;
    end else if (advance) begin
      shreg    <= shreg << WORD_W;
      word_idx <= last_word ? '0 : word_idx + 1'b1;
    end
  end

  assign word      = shreg[BLK_W-1 -: WORD_W];
  assign last_word = (word_idx == LAST_IDX);

endmodule

// File: rtl/aes_out_streamer.sv
// Drains AES result blocks from the output FIFO memory and sends them as a
// 32-bit AXI4-Stream; started by en, finished with a one-cycle en_o pulse.
`timescale 1ns/1ps
module aes_out_streamer
  import aes_pkg::*;
#(
  parameter int OUT_FIFO_ADDR_WIDTH = 9,
  parameter int OUT_FIFO_DATA_WIDTH = OUT_FIFO_DATA_WIDTH_DEF,
  parameter int AXIS_DATA_WIDTH     = AXIS_DATA_WIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic [OUT_FIFO_ADDR_WIDTH-1:0] blk_cnt,
  input  logic [0:OUT_FIFO_DATA_WIDTH-1] out_fifo_data,
  output logic                           out_fifo_r_e,
  output logic [OUT_FIFO_ADDR_WIDTH-1:0] out_fifo_addr,
  output logic [AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic                           busy,
  output logic                           en_o
);

  localparam int WPB = words_per_blk(OUT_FIFO_DATA_WIDTH, AXIS_DATA_WIDTH);
  localparam logic [OUT_FIFO_ADDR_WIDTH-1:0] ONE = OUT_FIFO_ADDR_WIDTH'(1);

  aes_out_state_t                 state, state_d;
  logic [OUT_FIFO_ADDR_WIDTH-1:0] remaining, remaining_d;
  logic [OUT_FIFO_ADDR_WIDTH-1:0] read_ptr, read_ptr_d;
  logic                           r_e_d, tvalid_d, en_o_d;
  logic                           ser_load, ser_adv, ser_last;
  logic [AXIS_DATA_WIDTH-1:0]     ser_word;
  logic                           hs;

  assign hs = m_axis_tvalid && m_axis_tready;

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d     = state;
    remaining_d = remaining;
    read_ptr_d  = read_ptr;
    r_e_d       = 1'b0;
    tvalid_d    = m_axis_tvalid;
    en_o_d      = 1'b0;
    ser_load    = 1'b0;
    ser_adv     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) begin
          remaining_d = blk_cnt;
          read_ptr_d  = '0;
          if (blk_cnt == '0) begin
            en_o_d = 1'b1;
          end else begin
            state_d = ST_FETCH;
            r_e_d   = 1'b1;
          end
        end
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        ser_load = 1'b1;
        tvalid_d = 1'b1;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (hs) begin
          ser_adv = 1'b1;
          if (ser_last) begin
            remaining_d = remaining - ONE;
            read_ptr_d  = read_ptr + ONE;
            tvalid_d    = 1'b0;
            if (remaining == ONE) begin
              en_o_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              r_e_d   = 1'b1;
              state_d = ST_FETCH;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and every registered output; reset clears all at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      remaining     <= '0;
      read_ptr      <= '0;
      out_fifo_r_e  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      en_o          <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_d;
      remaining     <= remaining_d;
      read_ptr      <= read_ptr_d;
      out_fifo_r_e  <= r_e_d;
      m_axis_tvalid <= tvalid_d;
      en_o          <= en_o_d;
      busy          <= (state_d != ST_IDLE);
    end
  end

  assign out_fifo_addr = read_ptr;

  aes_blk_serializer #(
    .BLK_W  (OUT_FIFO_DATA_WIDTH),
    .WORD_W (AXIS_DATA_WIDTH),
    .WPB    (WPB)
  ) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (ser_load),
    .blk       (out_fifo_data),
    .advance   (ser_adv),
    .word      (ser_word),
    .last_word (ser_last)
  );

  // Data and last are decoded from registers only, zero whenever not valid.
  assign m_axis_tdata = m_axis_tvalid ? ser_word : '0;
  assign m_axis_tlast = m_axis_tvalid && ser_last && (remaining == ONE);

endmodule

// File: tb/tb_aes_out_streamer.sv
// Bench for aes_out_streamer: memory model, expected-word queue and per-cycle
// compare, plus literal checks on timing and data of directed requests.
`timescale 1ns/1ps
module tb_aes_out_streamer;

  localparam int AW = 9;
  localparam int DW = 128;
  localparam int SW = 32;
  localparam int NW = DW / SW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic          tready = 1'b0;
  logic [AW-1:0] blk_cnt = '0;
  logic [DW-1:0] rdata;
  logic          r_e, tvalid, tlast, busy, en_o;
  logic [AW-1:0] addr;
  logic [SW-1:0] tdata;

  always #5 clk = ~clk;

  aes_out_streamer #(
    .OUT_FIFO_ADDR_WIDTH (AW),
    .OUT_FIFO_DATA_WIDTH (DW),
    .AXIS_DATA_WIDTH     (SW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .blk_cnt       (blk_cnt),
    .out_fifo_data (rdata),
    .out_fifo_r_e  (r_e),
    .out_fifo_addr (addr),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .busy          (busy),
    .en_o          (en_o)
  );

  // Output FIFO memory: data valid only in the cycle after a read.
  logic [DW-1:0] mem [1<<AW];
  always @(posedge clk) rdata <= r_e ? mem[addr] : {NW{32'hDEADBEEF}};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [SW:0]   exp_q[$];
  bit            active = 0;
  bit            pend_en_o = 0;
  bit            prev_stall = 0;
  bit            prev_tv = 0;
  logic [SW-1:0] prev_data;
  logic          prev_last;
  int            fetch_idx = 0;
  int            hs_total = 0, en_o_total = 0, fetch_total = 0;
  int            tv_rise_cyc = -1, en_o_cyc = -1;
  logic [SW-1:0] cap_data[$];
  logic          cap_last[$];
  int            hs_cyc[$];

  // Per-cycle compare against the request-level model.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      active     = 0;
      pend_en_o  = 0;
      prev_stall = 0;
      prev_tv    = 0;
    end else begin
      chk("en_o", en_o, pend_en_o);
      if (en_o) begin
        en_o_total++;
        en_o_cyc = cyc;
      end
      pend_en_o = 0;
      chk("busy", busy, active);
      if (r_e) begin
        chk("fetch_addr", addr, fetch_idx);
        fetch_idx++;
        fetch_total++;
      end
      if (!active) begin
        chk("idle_r_e", r_e, 0);
        chk("idle_tvalid", tvalid, 0);
      end
      if (prev_stall) begin
        chk("stall_tvalid", tvalid, 1);
        chk("stall_tdata", tdata, prev_data);
        chk("stall_tlast", tlast, prev_last);
      end
      if (tvalid && !prev_tv) tv_rise_cyc = cyc;
      if (en && !active) begin
        int n;
        n = int'(blk_cnt);
        if (n == 0) begin
          pend_en_o = 1;
        end else begin
          active    = 1;
          fetch_idx = 0;
          for (int b = 0; b < n; b++)
            for (int k = 0; k < NW; k++)
              exp_q.push_back({(b == n - 1) && (k == NW - 1), mem[b][DW-1-SW*k -: SW]});
        end
      end
      if (tvalid && tready) begin
        chk("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          logic [SW:0] e;
          e = exp_q.pop_front();
          chk("tdata", tdata, e[SW-1:0]);
          chk("tlast", tlast, e[SW]);
          if (exp_q.size() == 0) begin
            active    = 0;
            pend_en_o = 1;
          end
        end
        hs_total++;
        cap_data.push_back(tdata);
        cap_last.push_back(tlast);
        hs_cyc.push_back(cyc + 1);
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
      prev_tv    = tvalid;
    end
  end

  // tready driver: 0 off, 1 on, 2 random, 3 stall 20 cycles on tlast, 4 stop after 2 words.
  int rdy_mode = 1;
  int hs_base = 0;
  int stall_n = 0;
  always @(posedge clk) begin
    #1;
    if (rdy_mode != 3) stall_n = 0;
    case (rdy_mode)
      0: tready = 1'b0;
      1: tready = 1'b1;
      2: tready = ($urandom_range(0, 99) < 60);
      3: begin
        if (tvalid && tlast && stall_n < 20) begin
          tready = 1'b0;
          stall_n++;
        end else begin
          tready = 1'b1;
        end
      end
      default: tready = ((hs_total - hs_base) < 2);
    endcase
  end

  task automatic start(input int n, output int e);
    @(posedge clk); #1;
    en = 1'b1;
    blk_cnt = AW'(n);
    @(posedge clk); #1;
    e  = cyc;
    en = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk); #1;
      if (!busy && !active) done = 1;
    end
    chk("done_in_time", done, 1);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t, required below 500000", $time);
    $fatal(1);
  end

  initial begin
    int e, b0, e0, f0, h0;
    for (int i = 0; i < (1 << AW); i++)
      mem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_r_e", r_e, 0);
    chk("rst_addr", addr, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_en_o", en_o, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Single block, exact timing, tready held high
    mem[0] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    rdy_mode = 1;
    b0 = hs_total; e0 = en_o_total;
    start(1, e);
    wait_done(50);
    chk("t1_w0", cap_data[b0],   32'h00112233);
    chk("t1_w1", cap_data[b0+1], 32'h44556677);
    chk("t1_w2", cap_data[b0+2], 32'h8899AABB);
    chk("t1_w3", cap_data[b0+3], 32'hCCDDEEFF);
    chk("t1_last", {cap_last[b0], cap_last[b0+1], cap_last[b0+2], cap_last[b0+3]}, 4'b0001);
    for (int k = 0; k < NW; k++) chk("t1_hs_edge", hs_cyc[b0+k], e + 3 + k);
    chk("t1_tvalid_rise", tv_rise_cyc, e + 2);
    chk("t1_en_o_cycle", en_o_cyc, e + 6);
    chk("t1_en_o_count", en_o_total - e0, 1);

    // Three blocks with random backpressure
    for (int i = 0; i < 3; i++) mem[i] = {NW{32'(i)}};
    rdy_mode = 2;
    b0 = hs_total; e0 = en_o_total; f0 = fetch_total;
    start(3, e);
    wait_done(600);
    chk("t2_words", hs_total - b0, 12);
    chk("t2_fetches", fetch_total - f0, 3);
    chk("t2_w11", cap_data[b0+11], 32'h2);
    chk("t2_last11", cap_last[b0+11], 1);
    chk("t2_en_o_count", en_o_total - e0, 1);

    // Zero-block request
    rdy_mode = 1;
    b0 = hs_total; e0 = en_o_total; f0 = fetch_total;
    start(0, e);
    repeat (6) @(negedge clk);
    chk("t3_en_o_count", en_o_total - e0, 1);
    chk("t3_en_o_cycle", en_o_cyc, e);
    chk("t3_words", hs_total - b0, 0);
    chk("t3_fetches", fetch_total - f0, 0);

    // en while busy is ignored
    mem[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
    mem[1] = {$urandom(), $urandom(), $urandom(), $urandom()};
    b0 = hs_total; e0 = en_o_total;
    start(2, e);
    @(posedge clk);
    @(posedge clk); #1;
    en = 1'b1; blk_cnt = AW'(1);
    @(posedge clk); #1;
    en = 1'b0;
    wait_done(100);
    chk("t4_words", hs_total - b0, 8);
    chk("t4_en_o_count", en_o_total - e0, 1);

    // Reset during the third word with tready low
    mem[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
    hs_base = hs_total;
    rdy_mode = 4;
    e0 = en_o_total;
    start(1, e);
    for (int i = 0; i < 50 && (hs_total - hs_base) < 2; i++) @(negedge clk);
    chk("t5_two_words", hs_total - hs_base, 2);
    repeat (2) @(negedge clk);
    #2;
    chk("t5_pre_tvalid", tvalid, 1);
    reset = 1'b0;
    #1;
    chk("t5_r_e", r_e, 0);
    chk("t5_addr", addr, 0);
    chk("t5_tdata", tdata, 0);
    chk("t5_tvalid", tvalid, 0);
    chk("t5_tlast", tlast, 0);
    chk("t5_busy", busy, 0);
    chk("t5_en_o", en_o, 0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    rdy_mode = 1;
    repeat (3) @(negedge clk);
    chk("t5_no_en_o", en_o_total - e0, 0);
    mem[0] = 128'hA5A5A5A5_01020304_F0E0D0C0_7FFFFFFF;
    b0 = hs_total;
    start(1, e);
    wait_done(50);
    chk("t5_w0", cap_data[b0],   32'hA5A5A5A5);
    chk("t5_w3", cap_data[b0+3], 32'h7FFFFFFF);
    chk("t5_en_o_count", en_o_total - e0, 1);

    // tready held low for 20 cycles on the final word
    mem[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
    rdy_mode = 3;
    b0 = hs_total;
    start(1, e);
    wait_done(100);
    chk("t6_stall_cycles", stall_n, 20);
    chk("t6_last_edge", hs_cyc[b0+3], e + 6 + 20);
    chk("t6_en_o_cycle", en_o_cyc, e + 6 + 20);
    rdy_mode = 1;

    // Random requests under random backpressure
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) mem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      rdy_mode = 2;
      b0 = hs_total; h0 = en_o_total;
      start(n, e);
      wait_done(40 * n + 50);
      chk("rand_words", hs_total - b0, NW * n);
      chk("rand_en_o", en_o_total - h0, 1);
    end

    // Largest request: addresses 0..2^W-2
    for (int i = 0; i < (1 << AW); i++)
      mem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    rdy_mode = 1;
    b0 = hs_total; f0 = fetch_total;
    start((1 << AW) - 1, e);
    wait_done(4000);
    chk("max_words", hs_total - b0, NW * ((1 << AW) - 1));
    chk("max_fetches", fetch_total - f0, (1 << AW) - 1);
    chk("max_final_addr", addr, (1 << AW) - 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
